mem_access_ctrl: RTL and testbench

Sequencer between the IorD address mux and the unified instruction/data memory. It accepts one read or write request from the control unit at the mux-selected address and drives the memory port for the required wait cycles. It performs read-modify-write for byte/halfword stores and latches the loaded word into the MDR. It reports completion with a done pulse so the control FSM advances on a handshake rather than on fixed cycle counts.

---
 rtl/mem_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load or store between the IorD address mux
// and the unified instruction/data memory. Stores narrower than a word are
// done as read-modify-write, loads land in the MDR, and a one-cycle done
// pulse lets the control FSM advance on a handshake.
module mem_access_ctrl #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr_in,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [1:0]  size,
    input  logic        ld_signed,
    input  logic [31:0] wr_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mdr_out,
    output logic [31:0] ld_data,
    output logic        busy,
    output logic        done,
    output logic        err_align
);

    localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, WR, ERR, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            sgn_q;
    logic            is_wr_q;
    logic [15:0]     wdata_q;
    logic [31:0]     mem_addr_q;
    logic            mem_wr_q;
    logic [31:0]     mem_wdata_q;
    logic [31:0]     mdr_q;
    logic            done_q;
    logic            err_q;

    logic            req_word;
    logic            misaligned;
    logic [15:0]     ld_half;
    logic [7:0]      ld_byte;

    // Size code 11 behaves like a word; halfwords need an even address.
    assign req_word   = (size == 2'b00) || (size == 2'b11);
    assign misaligned = req_word ? (addr_in[1:0] != 2'b00)
                                 : ((size == 2'b01) && addr_in[0]);

    // Replace only the addressed little-endian lane(s) of the old word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [15:0] new_data,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off);
        logic [31:0] w;
        w = old_word;
        if (sz == 2'b01) begin
            if (off[1]) w[31:16] = new_data;
            else        w[15:0]  = new_data;
        end else if (sz == 2'b10) begin
            case (off)
                2'd0:    w[7:0]   = new_data[7:0];
                2'd1:    w[15:8]  = new_data[7:0];
                2'd2:    w[23:16] = new_data[7:0];
                default: w[31:24] = new_data[7:0];
            endcase
        end
        return w;
    endfunction

    // Access sequencer: accept, wait out read latency, write, then pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            sgn_q       <= 1'b0;
            is_wr_q     <= 1'b0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            mdr_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_rd || req_wr) begin
                        off_q   <= addr_in[1:0];
                        size_q  <= size;
                        sgn_q   <= ld_signed;
                        wdata_q <= wr_data[15:0];
                        is_wr_q <= !req_rd;
                        if (misaligned) begin
                            state_q <= ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (!req_rd && req_word) begin
                            state_q     <= WR;
                            mem_addr_q  <= {addr_in[31:2], 2'b00};
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= wr_data;
                        end else begin
                            state_q    <= RD_WAIT;
                            mem_addr_q <= {addr_in[31:2], 2'b00};
                            cnt_q      <= CW'(1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == CW'(RD_LAT)) begin
                        mdr_q <= mem_rdata;
                        if (is_wr_q) begin
                            state_q     <= WR;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= merge_lanes(mem_rdata, wdata_q, size_q, off_q);
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WR: begin
                    mem_wr_q <= 1'b0;
                    state_q  <= DONE;
                    done_q   <= 1'b1;
                end
                ERR: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Load result: pick the latched lane out of the MDR and extend it.
    always_comb begin
        ld_half = off_q[1] ? mdr_q[31:16] : mdr_q[15:0];
        case (off_q)
            2'd0:    ld_byte = mdr_q[7:0];
            2'd1:    ld_byte = mdr_q[15:8];
            2'd2:    ld_byte = mdr_q[23:16];
            default: ld_byte = mdr_q[31:24];
        endcase
        case (size_q)
            2'b01:   ld_data = {{16{sgn_q & ld_half[15]}}, ld_half};
            2'b10:   ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
            default: ld_data = mdr_q;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign mdr_out   = mdr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err_align = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: drives mem_access_ctrl against a latency-modelled
// memory; completions and memory writes are scored against queues of
// expected results pushed when each request is issued.
module tb_mem_access_ctrl;

    localparam int RD_LAT = 2;
    localparam int LOGN   = 24;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr_in;
    logic        req_rd;
    logic        req_wr;
    logic [1:0]  size;
    logic        ld_signed;
    logic [31:0] wr_data;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mdr_out;
    logic [31:0] ld_data;
    logic        busy;
    logic        done;
    logic        err_align;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          err;
        logic [31:0] mdr;
        logic [31:0] ld;
        bit          chkLd;
    } doneExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wrExp_t;

    doneExp_t doneQ[$];
    wrExp_t   wrQ[$];

    logic [31:0] memArr [0:15];
    logic [31:0] lastAddr;
    int          stableCnt = 0;
    logic        preEn = 1'b0;
    int          preIdx = 0;
    logic [31:0] preVal = '0;

    logic        logBusy [0:LOGN-1];
    logic        logWr   [0:LOGN-1];
    logic        logDone [0:LOGN-1];
    logic [31:0] logAddr [0:LOGN-1];

    mem_access_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr_in   (addr_in),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .size      (size),
        .ld_signed (ld_signed),
        .wr_data   (wr_data),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mdr_out   (mdr_out),
        .ld_data   (ld_data),
        .busy      (busy),
        .done      (done),
        .err_align (err_align)
    );

    always #5 clk = ~clk;

    // Memory array: bench preloads take priority over DUT writes.
    always @(posedge clk) begin
        if (preEn)       memArr[preIdx] <= preVal;
        else if (mem_wr) memArr[mem_addr[5:2]] <= mem_wdata;
    end

    // Read data is only valid once the address has been held RD_LAT cycles.
    always @(negedge clk) begin
        int n;
        n = ((mem_addr === lastAddr) && !mem_wr) ? stableCnt + 1 : 1;
        stableCnt <= n;
        lastAddr  <= mem_addr;
        mem_rdata <= (n >= RD_LAT) ? memArr[mem_addr[5:2]] : 32'hBAD0_BAD0;
    end

    // Completion scoreboard: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        doneExp_t e;
        if (reset_n && done) begin
            checks++;
            if (doneQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 required no completion pending");
            end else begin
                e = doneQ.pop_front();
                if (err_align !== e.err) begin
                    errors++;
                    $display("[TB] FAIL done_err_align: got %0b required %0b", err_align, e.err);
                end
                checks++;
                if (mdr_out !== e.mdr) begin
                    errors++;
                    $display("[TB] FAIL done_mdr: got %08h required %08h", mdr_out, e.mdr);
                end
                if (e.chkLd) begin
                    checks++;
                    if (ld_data !== e.ld) begin
                        errors++;
                        $display("[TB] FAIL done_ld_data: got %08h required %08h", ld_data, e.ld);
                    end
                end
            end
        end
    end

    // Write scoreboard: every mem_wr cycle must match the oldest expected write.
    always @(negedge clk) begin
        wrExp_t w;
        if (mem_wr === 1'b1) begin
            checks++;
            if (wrQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got write %08h@%08h required none", mem_wdata, mem_addr);
            end else begin
                w = wrQ.pop_front();
                if ((mem_addr !== w.addr) || (mem_wdata !== w.data)) begin
                    errors++;
                    $display("[TB] FAIL write_value: got %08h@%08h required %08h@%08h",
                             mem_wdata, mem_addr, w.data, w.addr);
                end
            end
        end
    end

    // Load a memory word from the bench side while the DUT is idle.
    task automatic preload(input int idx, input logic [31:0] val);
        preIdx = idx;
        preVal = val;
        preEn  = 1'b1;
        @(negedge clk);
        preEn  = 1'b0;
    endtask

    // Issue one request in the current (idle) cycle and log each following cycle.
    task automatic runReq(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic sgn, input logic [31:0] wd,
                          output int doneCyc);
        doneCyc = -1;
        for (int k = 0; k < LOGN; k++) begin
            logBusy[k] = 1'b0;
            logWr[k]   = 1'b0;
            logDone[k] = 1'b0;
            logAddr[k] = '0;
        end
        req_rd = rd; req_wr = wr; addr_in = a; size = sz; ld_signed = sgn; wr_data = wd;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_rd = 1'b0;
                req_wr = 1'b0;
            end
            logBusy[k] = busy;
            logWr[k]   = mem_wr;
            logDone[k] = done;
            logAddr[k] = mem_addr;
            if (done && doneCyc < 0) doneCyc = k;
            if (doneCyc >= 0 && k == doneCyc + 1) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_rd = 1'b0; req_wr = 1'b0; addr_in = '0; size = 2'b00; ld_signed = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done: got %0b required 0", done); end
        checks++; if (err_align !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b required 0", err_align); end
        checks++; if (mem_wr !== 1'b0)    begin errors++; $display("[TB] FAIL reset_mem_wr: got %0b required 0", mem_wr); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %08h required 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %08h required 0", mem_wdata); end
        checks++; if (mdr_out !== 32'h0)  begin errors++; $display("[TB] FAIL reset_mdr: got %08h required 0", mdr_out); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_release_busy: got %0b required 0", busy); end
    endtask

    task automatic test_word_load();
        int dc;
        int wrCnt;
        preload(4, 32'hDEAD_BEEF);
        doneQ.push_back('{err: 1'b0, mdr: 32'hDEAD_BEEF, ld: 32'hDEAD_BEEF, chkLd: 1'b1});
        runReq(1'b1, 1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0, dc);
        checks++; if (dc != 3) begin errors++; $display("[TB] FAIL word_load_done_cycle: got %0d required 3", dc); end
        checks++;
        if (logAddr[1] !== 32'h10 || logAddr[2] !== 32'h10) begin
            errors++; $display("[TB] FAIL word_load_addr: got %08h,%08h required 00000010", logAddr[1], logAddr[2]);
        end
        wrCnt = 0;
        for (int k = 1; k < LOGN; k++) if (logWr[k]) wrCnt++;
        checks++; if (wrCnt != 0) begin errors++; $display("[TB] FAIL word_load_no_write: got %0d writes required 0", wrCnt); end
        checks++;
        if (!(logBusy[1] && logBusy[2] && logBusy[3]) || logBusy[4] !== 1'b0) begin
            errors++; $display("[TB] FAIL word_load_busy: got %0b%0b%0b%0b required 1110",
                               logBusy[1], logBusy[2], logBusy[3], logBusy[4]);
        end
    endtask

    task automatic test_subword_load();
        logic [31:0] tAddr [0:5];
        logic [1:0]  tSize [0:5];
        logic        tSgn  [0:5];
        logic [31:0] tLd   [0:5];
        int dc;
        tAddr = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h12};
        tSize = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        tSgn  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tLd   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_0011, 32'h0000_0000, 32'hFFFF_FFFF};
        preload(4, 32'h80FF_0011);
        for (int i = 0; i < 6; i++) begin
            doneQ.push_back('{err: 1'b0, mdr: 32'h80FF_0011, ld: tLd[i], chkLd: 1'b1});
            runReq(1'b1, 1'b0, tAddr[i], tSize[i], tSgn[i], 32'h0, dc);
            checks++; if (dc != 3) begin errors++; $display("[TB] FAIL subword_load_done_cycle[%0d]: got %0d required 3", i, dc); end
        end
    endtask

    task automatic test_store();
        int dc;
        int wrCnt;
        preload(8, 32'h1111_2222);
        wrQ.push_back('{addr: 32'h20, data: 32'hABCD_2222});
        doneQ.push_back('{err: 1'b0, mdr: 32'h1111_2222, ld: 32'h0000_1111, chkLd: 1'b1});
        runReq(1'b0, 1'b1, 32'h22, 2'b01, 1'b0, 32'h5555_ABCD, dc);
        wrCnt = 0;
        for (int k = 1; k < LOGN; k++) if (logWr[k]) wrCnt++;
        checks++; if (dc != 4) begin errors++; $display("[TB] FAIL half_store_done_cycle: got %0d required 4", dc); end
        checks++;
        if (wrCnt != 1 || logWr[3] !== 1'b1 || logAddr[3] !== 32'h20) begin
            errors++; $display("[TB] FAIL half_store_pulse: got %0d writes wr3=%0b addr3=%08h required 1,1,00000020",
                               wrCnt, logWr[3], logAddr[3]);
        end
        wrQ.push_back('{addr: 32'h20, data: 32'hABCD_7E22});
        doneQ.push_back('{err: 1'b0, mdr: 32'hABCD_2222, ld: 32'h0000_0022, chkLd: 1'b1});
        runReq(1'b0, 1'b1, 32'h21, 2'b10, 1'b1, 32'h0000_007E, dc);
        checks++; if (dc != 4) begin errors++; $display("[TB] FAIL byte_store_done_cycle: got %0d required 4", dc); end
        wrQ.push_back('{addr: 32'h24, data: 32'hCAFE_F00D});
        doneQ.push_back('{err: 1'b0, mdr: 32'hABCD_2222, ld: 32'hABCD_2222, chkLd: 1'b1});
        runReq(1'b0, 1'b1, 32'h24, 2'b00, 1'b0, 32'hCAFE_F00D, dc);
        checks++; if (dc != 2) begin errors++; $display("[TB] FAIL word_store_done_cycle: got %0d required 2", dc); end
        checks++; if (logWr[1] !== 1'b1) begin errors++; $display("[TB] FAIL word_store_pulse: got wr1=%0b required 1", logWr[1]); end
        doneQ.push_back('{err: 1'b0, mdr: 32'hABCD_7E22, ld: 32'hABCD_7E22, chkLd: 1'b1});
        runReq(1'b1, 1'b0, 32'h20, 2'b00, 1'b0, 32'h0, dc);
        checks++; if (dc != 3) begin errors++; $display("[TB] FAIL readback_done_cycle: got %0d required 3", dc); end
    endtask

    task automatic test_misaligned();
        logic [31:0] tAddr [0:3];
        logic [1:0]  tSize [0:3];
        logic        tWr   [0:3];
        int dc;
        int wrCnt;
        tAddr = '{32'h06, 32'h05, 32'h22, 32'h02};
        tSize = '{2'b00, 2'b01, 2'b00, 2'b11};
        tWr   = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            doneQ.push_back('{err: 1'b1, mdr: 32'hABCD_7E22, ld: 32'h0, chkLd: 1'b0});
            runReq(!tWr[i], tWr[i], tAddr[i], tSize[i], 1'b0, 32'h1234_5678, dc);
            wrCnt = 0;
            for (int k = 1; k < LOGN; k++) if (logWr[k]) wrCnt++;
            checks++; if (dc != 1) begin errors++; $display("[TB] FAIL misaligned_done_cycle[%0d]: got %0d required 1", i, dc); end
            checks++;
            if (wrCnt != 0 || logBusy[1] !== 1'b1 || logBusy[2] !== 1'b0) begin
                errors++; $display("[TB] FAIL misaligned_shape[%0d]: got writes=%0d busy=%0b%0b required 0,10",
                                   i, wrCnt, logBusy[1], logBusy[2]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int dc;
        int wrSeen;
        preload(12, 32'h1234_5678);
        req_wr = 1'b1; req_rd = 1'b0; addr_in = 32'h31; size = 2'b10; ld_signed = 1'b0; wr_data = 32'h0000_00EE;
        @(negedge clk);
        req_wr = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_before: got %0b required 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_align !== 1'b0 || mem_wr !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mdr_out !== 32'h0) begin
            errors++; $display("[TB] FAIL abort_outputs: got busy=%0b done=%0b wr=%0b addr=%08h wdata=%08h mdr=%08h required all 0",
                               busy, done, mem_wr, mem_addr, mem_wdata, mdr_out);
        end
        wrSeen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_wr !== 1'b0) wrSeen++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_wr !== 1'b0) wrSeen++;
        end
        checks++; if (wrSeen != 0) begin errors++; $display("[TB] FAIL abort_no_write: got %0d write cycles required 0", wrSeen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got busy=%0b required 0", busy); end
        checks++; if (memArr[12] !== 32'h1234_5678) begin errors++; $display("[TB] FAIL abort_memory: got %08h required 12345678", memArr[12]); end
        doneQ.push_back('{err: 1'b0, mdr: 32'h1234_5678, ld: 32'h1234_5678, chkLd: 1'b1});
        runReq(1'b1, 1'b0, 32'h30, 2'b00, 1'b0, 32'h0, dc);
        checks++; if (dc != 3) begin errors++; $display("[TB] FAIL abort_followup_done: got %0d required 3", dc); end
    endtask

    task automatic test_back_to_back();
        int dc;
        int wrCnt;
        int firstDone;
        int secondDone;
        preload(5, 32'hA5A5_0001);
        preload(6, 32'h0000_5A5A);
        doneQ.push_back('{err: 1'b0, mdr: 32'hA5A5_0001, ld: 32'hA5A5_0001, chkLd: 1'b1});
        runReq(1'b1, 1'b1, 32'h14, 2'b00, 1'b0, 32'hFFFF_FFFF, dc);
        wrCnt = 0;
        for (int k = 1; k < LOGN; k++) if (logWr[k]) wrCnt++;
        checks++; if (dc != 3) begin errors++; $display("[TB] FAIL both_req_done_cycle: got %0d required 3", dc); end
        checks++; if (wrCnt != 0) begin errors++; $display("[TB] FAIL both_req_no_write: got %0d writes required 0", wrCnt); end

        doneQ.push_back('{err: 1'b0, mdr: 32'h0000_5A5A, ld: 32'h0000_5A5A, chkLd: 1'b1});
        doneQ.push_back('{err: 1'b0, mdr: 32'hA5A5_0001, ld: 32'hA5A5_0001, chkLd: 1'b1});
        firstDone = -1;
        secondDone = -1;
        req_rd = 1'b1; req_wr = 1'b0; addr_in = 32'h18; size = 2'b00; ld_signed = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            logBusy[k] = busy;
            logAddr[k] = mem_addr;
            if (done) begin
                if (firstDone < 0) firstDone = k;
                else if (secondDone < 0) secondDone = k;
            end
            if (k == 1) addr_in = 32'h14;
            if (k == 5) req_rd = 1'b0;
        end
        checks++;
        if (firstDone != 3 || secondDone != 7) begin
            errors++; $display("[TB] FAIL back_to_back_done: got %0d,%0d required 3,7", firstDone, secondDone);
        end
        checks++;
        if (logBusy[4] !== 1'b0 || logBusy[5] !== 1'b1) begin
            errors++; $display("[TB] FAIL back_to_back_accept: got busy4=%0b busy5=%0b required 0,1", logBusy[4], logBusy[5]);
        end
        checks++;
        if (logAddr[1] !== 32'h18 || logAddr[5] !== 32'h14) begin
            errors++; $display("[TB] FAIL back_to_back_addr: got %08h,%08h required 00000018,00000014", logAddr[1], logAddr[5]);
        end
    endtask

    // Hard time limit so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_word_load();
        test_subword_load();
        test_store();
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (doneQ.size() != 0) begin errors++; $display("[TB] FAIL done_queue_drained: got %0d left required 0", doneQ.size()); end
        checks++;
        if (wrQ.size() != 0) begin errors++; $display("[TB] FAIL write_queue_drained: got %0d left required 0", wrQ.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
